mnist_pixel_streamer: RTL and testbench

- Source end of the network's pixel stream: buffers one input frame written by the host, then replays it in raster order.
- Output is a valid-qualified beat stream (pix_vld / pix_dout) that connects directly to the top-level input_vld / input_din of the CNN pipeline.
- Sits between the host/loader interface and the first depthwise-conv layer.
- Adds frame framing (pix_last, done), programmable inter-pixel gap, and abort.

---
 rtl/mnist_pixel_streamer_pkg.sv | 22 ++
 rtl/mnist_frame_ram.sv | 23 ++
 rtl/mnist_pixel_streamer.sv | 138 +++++++++++++
 tb/tb_mnist_pixel_streamer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pixel_streamer_pkg.sv
// Shared constants and stream FSM encoding for the MNIST pixel source and its loader benches.
package mnist_pixel_streamer_pkg;

  localparam int N             = 8;
  localparam int INPUT_CHANNEL = 1;
  localparam int INPUT_SIZE    = 28;
  localparam int PIXELS        = INPUT_SIZE * INPUT_SIZE;
  localparam int ADDR_W        = $clog2(PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } stream_state_e;

  // Width of the inter-pixel gap counter; never zero so GAP=0 builds cleanly.
  function automatic int gap_w(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/mnist_frame_ram.sv
// One channel lane of the frame buffer: simple dual-port RAM, synchronous read, no reset.
module mnist_frame_ram #(
  parameter int DEPTH  = 784,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
)(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mnist_pixel_streamer.sv
// Buffers one host-written frame and replays it in raster order as a valid-qualified beat stream.
module mnist_pixel_streamer #(
  parameter int N             = mnist_pixel_streamer_pkg::N,
  parameter int INPUT_CHANNEL = mnist_pixel_streamer_pkg::INPUT_CHANNEL,
  parameter int INPUT_SIZE    = mnist_pixel_streamer_pkg::INPUT_SIZE,
  parameter int GAP           = 0,
  localparam int PIXELS       = INPUT_SIZE * INPUT_SIZE,
  localparam int ADDR_W       = $clog2(PIXELS),
  localparam int W            = INPUT_CHANNEL * N
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              start,
  input  logic              abort,
  output logic [W-1:0]      pix_dout,
  output logic              pix_vld,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);
  import mnist_pixel_streamer_pkg::*;

  // Stage 1 = RAM output register, stage 2 = pix_dout register.
  localparam int STAGES = 2;
  localparam int GAP_W  = gap_w(GAP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  stream_state_e state;
  logic [ADDR_W-1:0] rd_addr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:1]   last_pipe;
  logic [INPUT_CHANNEL-1:0][N-1:0] ram_q;

  logic addr_ok, ram_we, wr_bad, start_ok, abort_ok;
  logic issue, issue_last, frame_end;

  assign busy       = (state != ST_IDLE);
  assign addr_ok    = 32'(wr_addr) < PIXELS;
  assign ram_we     = wr_en && !busy && addr_ok;
  assign wr_bad     = wr_en && (busy || !addr_ok);
  assign start_ok   = start && !busy;
  assign abort_ok   = abort && busy;
  assign issue      = (state == ST_READ) && !abort;
  assign issue_last = issue && (rd_addr == LAST_ADDR);
  // Frame completes once the last beat sits in the output register.
  assign frame_end  = (state == ST_DONE) && last_pipe[STAGES] && !abort;

  assign pix_vld  = vld_pipe[STAGES];
  assign pix_last = last_pipe[STAGES];

  for (genvar c = 0; c < INPUT_CHANNEL; c++) begin : g_lane
    mnist_frame_ram #(
      .DEPTH (PIXELS),
      .WIDTH (N),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk    (clk),
      .wr_en  (ram_we),
      .wr_addr(wr_addr),
      .wr_data(wr_data[c*N +: N]),
      .rd_en  (issue),
      .rd_addr(rd_addr),
      .rd_data(ram_q[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      gap_cnt <= '0;
    end else if (abort_ok) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_READ;
            rd_addr <= '0;
          end
        end
        ST_READ: begin
          if (rd_addr == LAST_ADDR) begin
            state <= ST_DONE;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            gap_cnt <= '0;
            state   <= (GAP > 0) ? ST_GAP : ST_READ;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_END) begin
            gap_cnt <= '0;
            state   <= ST_READ;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (last_pipe[STAGES]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      pix_dout  <= '0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      done <= frame_end;
      if (abort_ok) begin
        vld_pipe  <= '0;
        last_pipe <= '0;
      end else begin
        vld_pipe  <= {vld_pipe[STAGES-1:1], issue};
        last_pipe <= {last_pipe[STAGES-1:1], issue_last};
      end
      if (vld_pipe[1] && !abort_ok) pix_dout <= ram_q;
      // A rejected write in the same cycle as an accepted start stays flagged.
      if (wr_bad)        wr_err <= 1'b1;
      else if (start_ok) wr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mnist_pixel_streamer.sv
// Drives a GAP=0 and a GAP=2 streamer with shared stimulus and checks both against a beat-schedule model.
module tb_mnist_pixel_streamer;
  localparam int N   = 8;
  localparam int IC  = 1;
  localparam int SZ  = 28;
  localparam int PIX = SZ * SZ;
  localparam int AW  = 10;

  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [IC*N-1:0] wr_data = '0;
  logic [IC*N-1:0] dout [2];
  logic [1:0] vld, last, busy, done, wr_err;

  always #5 clk = ~clk;

  mnist_pixel_streamer #(.N(N), .INPUT_CHANNEL(IC), .INPUT_SIZE(SZ), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .pix_dout(dout[0]), .pix_vld(vld[0]), .pix_last(last[0]),
    .busy(busy[0]), .done(done[0]), .wr_err(wr_err[0]));

  mnist_pixel_streamer #(.N(N), .INPUT_CHANNEL(IC), .INPUT_SIZE(SZ), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .pix_dout(dout[1]), .pix_vld(vld[1]), .pix_last(last[1]),
    .busy(busy[1]), .done(done[1]), .wr_err(wr_err[1]));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Edges from start acceptance to the pix_last beat.
  function automatic int last_t(input int d);
    return (PIX - 1) * (gap_of(d) + 1) + 2;
  endfunction

  // Behavioural model: frame buffer contents plus position in the beat schedule.
  logic [7:0] mem [2][PIX];
  bit act_m [2];
  int t_m   [2];
  bit err_m [2];
  bit done_m[2];
  int cyc = 0;

  int st_beats[2], st_first[2], st_last_cnt[2], st_last_cyc[2], st_last_data[2];
  int st_done_cnt[2], st_done_cyc[2], st_start_cyc[2];

  initial begin
    bit bad, ev;
    int k;
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        done_m[d] = 0;
        if (!rst_n) begin
          act_m[d] = 0; t_m[d] = 0; err_m[d] = 0;
        end else begin
          bad = wr_en && (act_m[d] || wr_addr >= PIX);
          if (wr_en && !bad) mem[d][wr_addr] = wr_data;
          if (act_m[d]) begin
            if (abort) act_m[d] = 0;
            else begin
              t_m[d]++;
              if (t_m[d] == last_t(d) + 1) begin act_m[d] = 0; done_m[d] = 1; end
            end
          end else if (start) begin
            act_m[d] = 1; t_m[d] = 0; err_m[d] = 0; st_start_cyc[d] = cyc;
          end
          if (bad) err_m[d] = 1;
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        ev = act_m[d] && t_m[d] >= 2 && ((t_m[d] - 2) % (gap_of(d) + 1)) == 0;
        k  = ev ? (t_m[d] - 2) / (gap_of(d) + 1) : 0;
        chk($sformatf("busy%0d@%0d", d, cyc), busy[d], act_m[d]);
        chk($sformatf("vld%0d@%0d", d, cyc), vld[d], ev);
        chk($sformatf("last%0d@%0d", d, cyc), last[d], ev && k == PIX - 1);
        chk($sformatf("done%0d@%0d", d, cyc), done[d], done_m[d]);
        chk($sformatf("wr_err%0d@%0d", d, cyc), wr_err[d], err_m[d]);
        if (ev) chk($sformatf("dout%0d_k%0d@%0d", d, k, cyc), dout[d], mem[d][k]);
        if (vld[d] === 1'b1) begin
          st_beats[d]++;
          if (st_beats[d] == 1) st_first[d] = cyc;
          if (last[d] === 1'b1) begin
            st_last_cnt[d]++; st_last_cyc[d] = cyc; st_last_data[d] = int'(dout[d]);
          end
        end
        if (done[d] === 1'b1) begin st_done_cnt[d]++; st_done_cyc[d] = cyc; end
      end
    end
  end

  task automatic clr_stats();
    for (int d = 0; d < 2; d++) begin
      st_beats[d] = 0; st_first[d] = -1; st_last_cnt[d] = 0; st_last_cyc[d] = -1;
      st_last_data[d] = -1; st_done_cnt[d] = 0; st_done_cyc[d] = -1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy !== 2'b00 && i < 3000) begin @(negedge clk); i++; end
    chk("idle_within_bound", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_beats(input int n);
    int i = 0;
    while (st_beats[0] < n && i < 3000) begin @(negedge clk); i++; end
    chk("beat_wait", st_beats[0], n);
  endtask

  task automatic frame_checks(input string tag, input int ld0, input int ld1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_beats%0d", tag, d), st_beats[d], PIX);
      chk($sformatf("%s_first_lat%0d", tag, d), st_first[d] - st_start_cyc[d], 2);
      chk($sformatf("%s_last_cnt%0d", tag, d), st_last_cnt[d], 1);
      chk($sformatf("%s_last_data%0d", tag, d), st_last_data[d], (d == 0) ? ld0 : ld1);
      chk($sformatf("%s_span%0d", tag, d), st_last_cyc[d] - st_first[d], (d == 0) ? 783 : 2349);
      chk($sformatf("%s_done_cnt%0d", tag, d), st_done_cnt[d], 1);
      chk($sformatf("%s_done_after_last%0d", tag, d), st_done_cyc[d] - st_last_cyc[d], 1);
    end
  endtask

  task automatic write_px(input int a, input int v);
    @(negedge clk); wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'(v);
    @(negedge clk); wr_en = 1'b0;
  endtask

  initial begin
    clr_stats();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_dout0", dout[0], 0);
    chk("rst_err", wr_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < PIX; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'(i % 256);
    end
    @(negedge clk); wr_en = 1'b0;

    // Plain frame, both gap settings.
    clr_stats(); pulse_start(); wait_idle();
    frame_checks("plain", 15, 15);

    // Write and restart while streaming are rejected.
    clr_stats(); pulse_start(); repeat (10) @(negedge clk);
    write_px(5, 8'hAA);
    repeat (3) @(negedge clk);
    pulse_start(); repeat (3) @(negedge clk);
    chk("busy_write_err", wr_err, 2'b11);
    wait_idle();
    frame_checks("busy_wr", 15, 15);
    chk("err_sticky", wr_err, 2'b11);

    // Out-of-range write in idle, cleared by the next start.
    clr_stats(); pulse_start();
    chk("err_cleared", wr_err, 0);
    wait_idle();
    write_px(800, 8'h77);
    chk("oob_err", wr_err, 2'b11);
    clr_stats(); pulse_start();
    chk("oob_err_cleared", wr_err, 0);
    wait_idle();
    frame_checks("oob", 15, 15);

    // Abort after beat 100.
    clr_stats(); pulse_start(); wait_beats(100);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_vld", vld, 0);
    chk("abort_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done0", st_done_cnt[0], 0);
    chk("abort_no_last0", st_last_cnt[0], 0);
    chk("abort_beats0", st_beats[0], 100);
    clr_stats(); pulse_start(); wait_idle();
    frame_checks("replay", 15, 15);

    // Asynchronous reset mid-frame.
    clr_stats(); pulse_start(); wait_beats(300);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", last, 0);
    chk("arst_dout0", dout[0], 0);
    chk("arst_dout1", dout[1], 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    clr_stats(); pulse_start(); wait_idle();
    frame_checks("post_rst", 15, 15);

    // Randomised host traffic, starts and aborts.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      wr_en   = ($urandom % 6) == 0;
      wr_addr = AW'($urandom_range(0, 849));
      wr_data = 8'($urandom);
      start   = ($urandom % 150) == 0;
      abort   = ($urandom % 400) == 0;
    end
    @(negedge clk); wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    wait_idle();
    clr_stats(); pulse_start(); wait_idle();
    frame_checks("rand", int'(mem[0][PIX-1]), int'(mem[1][PIX-1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
